// File: rtl/vga_tile_plot_arbiter.sv
// Round-robin arbiter that shares one VGA plot port between tile requesters
// and a full-screen clear, emitting each TILE x TILE block one pixel per cycle.
`timescale 1ns/1ps

module vga_tile_plot_arbiter #(
    parameter int N_REQ = 3,
    parameter int TILE  = 3,
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_x,
    input  logic [7*N_REQ-1:0]   req_y,
    input  logic [3*N_REQ-1:0]   req_colour,
    input  logic                 clear_req,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 clear_done,
    output logic                 busy,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [2:0]           vga_colour,
    output logic                 vga_plot,
    output logic [2:0]           dbg_state
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [7:0] TILE_LAST_C = 8'(TILE - 1);
    localparam logic [6:0] TILE_LAST_R = 7'(TILE - 1);
    localparam logic [7:0] X_LAST      = 8'(X_MAX - 1);
    localparam logic [6:0] Y_LAST      = 7'(Y_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRAW     = 3'd1,
        S_DONE     = 3'd2,
        S_CLEAR    = 3'd3,
        S_CLR_DONE = 3'd4
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_last;
    logic [7:0]      r_col;
    logic [6:0]      r_row;
    logic [7:0]      r_base_x;
    logic [6:0]      r_base_y;
    logic [2:0]      r_colour;

    logic            w_any;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_cand;
    logic [7:0]      w_sel_x;
    logic [6:0]      w_sel_y;
    logic [2:0]      w_sel_colour;
    logic [8:0]      w_sum_x;
    logic [7:0]      w_sum_y;
    logic            w_in_screen;
    logic [N_REQ-1:0] w_owner_oh;

    // Search starts just after the last owner, so a requester that keeps
    // asserting req after its done drops to lowest priority.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IW'((int'(r_last) + k) % N_REQ);
            if (!w_any && req[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_colour = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == IW'(i)) begin
                w_sel_x      = req_x[8*i +: 8];
                w_sel_y      = req_y[7*i +: 7];
                w_sel_colour = req_colour[3*i +: 3];
            end
        end
    end

    always_comb begin
        w_owner_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_owner_oh[i] = (r_owner == IW'(i));
        end
    end

    // Widened sums detect pixels that fall off the right or bottom edge.
    assign w_sum_x     = {1'b0, r_base_x} + {1'b0, r_col};
    assign w_sum_y     = {1'b0, r_base_y} + {1'b0, r_row};
    assign w_in_screen = (w_sum_x < 9'(X_MAX)) && (w_sum_y < 8'(Y_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_last   <= IW'(N_REQ - 1);
            r_col    <= '0;
            r_row    <= '0;
            r_base_x <= '0;
            r_base_y <= '0;
            r_colour <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear_req) begin
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= S_CLEAR;
                    end else if (w_any) begin
                        r_owner  <= w_win;
                        r_base_x <= w_sel_x;
                        r_base_y <= w_sel_y;
                        r_colour <= w_sel_colour;
                        r_col    <= '0;
                        r_row    <= '0;
                        r_state  <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (r_col == TILE_LAST_C) begin
                        r_col <= '0;
                        if (r_row == TILE_LAST_R) begin
                            r_row   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_row <= r_row + 7'd1;
                        end
                    end else begin
                        r_col <= r_col + 8'd1;
                    end
                end
                S_DONE: begin
                    r_last  <= r_owner;
                    r_state <= S_IDLE;
                end
                S_CLEAR: begin
                    if (r_col == X_LAST) begin
                        r_col <= '0;
                        if (r_row == Y_LAST) begin
                            r_row   <= '0;
                            r_state <= S_CLR_DONE;
                        end else begin
                            r_row <= r_row + 7'd1;
                        end
                    end else begin
                        r_col <= r_col + 8'd1;
                    end
                end
                S_CLR_DONE: r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state, counters and latches.
    always_comb begin
        gnt        = '0;
        done       = '0;
        clear_done = 1'b0;
        busy       = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        case (r_state)
            S_DRAW: begin
                gnt        = w_owner_oh;
                busy       = 1'b1;
                vga_x      = w_sum_x[7:0];
                vga_y      = w_sum_y[6:0];
                vga_colour = r_colour;
                vga_plot   = w_in_screen;
            end
            S_DONE: begin
                gnt  = w_owner_oh;
                done = w_owner_oh;
                busy = 1'b1;
            end
            S_CLEAR: begin
                busy     = 1'b1;
                vga_x    = r_col;
                vga_y    = r_row;
                vga_plot = 1'b1;
            end
            S_CLR_DONE: begin
                busy       = 1'b1;
                clear_done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_vga_tile_plot_arbiter.sv
// Directed self-checking bench for vga_tile_plot_arbiter: tile bursts,
// round-robin order, clear priority, clipping, input stability and reset.
`timescale 1ns/1ps

module tb_vga_tile_plot_arbiter;

    localparam int N_REQ = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_x;
    logic [7*N_REQ-1:0] req_y;
    logic [3*N_REQ-1:0] req_colour;
    logic               clear_req;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic               clear_done;
    logic               busy;
    logic [7:0]         vga_x;
    logic [6:0]         vga_y;
    logic [2:0]         vga_colour;
    logic               vga_plot;
    logic [2:0]         dbg_state;

    int errors = 0;
    int checks = 0;

    vga_tile_plot_arbiter #(
        .N_REQ(3), .TILE(3), .X_MAX(160), .Y_MAX(120)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .clear_req(clear_req), .gnt(gnt), .done(done),
        .clear_done(clear_done), .busy(busy), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic set_tile(input int i, input logic [7:0] x, input logic [6:0] y,
                            input logic [2:0] c);
        req_x[8*i +: 8]      = x;
        req_y[7*i +: 7]      = y;
        req_colour[3*i +: 3] = c;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; clear_req = 1'b0;
        req_x = '0; req_y = '0; req_colour = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (gnt !== 3'b000 || done !== 3'b000 || clear_done !== 1'b0 || busy !== 1'b0 ||
            vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0 || vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b done=%b cdone=%b busy=%b x=%0d y=%0d col=%0d plot=%b, required all 0",
                     gnt, done, clear_done, busy, vga_x, vga_y, vga_colour, vga_plot);
        end
        checks++;
        if (dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d required 0", dbg_state);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== 3'b000 || vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b gnt=%b plot=%b required 0/000/0", busy, gnt, vga_plot);
        end
    endtask

    task automatic test_single_tile();
        logic [7:0] ex;
        logic [6:0] ey;
        set_tile(0, 8'd10, 7'd20, 3'b100);
        req = 3'b001;
        for (int p = 0; p < 9; p++) begin
            @(negedge clk);
            ex = 8'(10 + p % 3);
            ey = 7'(20 + p / 3);
            checks++;
            if (gnt !== 3'b001 || vga_plot !== 1'b1 || vga_x !== ex || vga_y !== ey ||
                vga_colour !== 3'b100 || done !== 3'b000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_tile_px%0d: gnt=%b plot=%b x=%0d y=%0d col=%b done=%b busy=%b, required 001/1/%0d/%0d/100/000/1",
                         p, gnt, vga_plot, vga_x, vga_y, vga_colour, done, busy, ex, ey);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 3'b001 || gnt !== 3'b001 || vga_plot !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_tile_done: done=%b gnt=%b plot=%b busy=%b, required 001/001/0/1",
                     done, gnt, vga_plot, busy);
        end
        req = 3'b000;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== 3'b000 || done !== 3'b000) begin
            errors++;
            $display("FAIL single_tile_idle: busy=%b gnt=%b done=%b, required 0/000/000", busy, gnt, done);
        end
    endtask

    task automatic test_round_robin();
        int order[4] = '{0, 1, 2, 0};
        int bx[3]    = '{10, 30, 50};
        int by[3]    = '{20, 40, 60};
        logic [2:0] bc[3] = '{3'd1, 3'd2, 3'd3};
        logic [2:0] oh;
        int w;
        rst = 1'b0;
        set_tile(0, 8'd10, 7'd20, 3'd1);
        set_tile(1, 8'd30, 7'd40, 3'd2);
        set_tile(2, 8'd50, 7'd60, 3'd3);
        req = 3'b111;
        @(negedge clk);
        rst = 1'b1;
        for (int b = 0; b < 4; b++) begin
            w  = order[b];
            oh = 3'(1 << w);
            for (int p = 0; p < 9; p++) begin
                @(negedge clk);
                checks++;
                if (gnt !== oh || vga_plot !== 1'b1 || vga_x !== 8'(bx[w] + p % 3) ||
                    vga_y !== 7'(by[w] + p / 3) || vga_colour !== bc[w]) begin
                    errors++;
                    $display("FAIL rr_burst%0d_px%0d: gnt=%b plot=%b x=%0d y=%0d col=%0d, required %b/1/%0d/%0d/%0d",
                             b, p, gnt, vga_plot, vga_x, vga_y, vga_colour, oh,
                             bx[w] + p % 3, by[w] + p / 3, bc[w]);
                end
            end
            @(negedge clk);
            checks++;
            if (done !== oh || gnt !== oh) begin
                errors++;
                $display("FAIL rr_done%0d: done=%b gnt=%b required %b", b, done, gnt, oh);
            end
            if (b == 3) req = 3'b000;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || gnt !== 3'b000) begin
                errors++;
                $display("FAIL rr_idle%0d: busy=%b gnt=%b required 0/000", b, busy, gnt);
            end
        end
    endtask

    task automatic test_clipping();
        int xs;
        int ys;
        logic ep;
        set_tile(2, 8'd158, 7'd118, 3'b010);
        req = 3'b100;
        for (int p = 0; p < 9; p++) begin
            @(negedge clk);
            xs = 158 + p % 3;
            ys = 118 + p / 3;
            ep = (xs < 160) && (ys < 120);
            checks++;
            if (gnt !== 3'b100 || vga_plot !== ep || vga_x !== 8'(xs) || vga_y !== 7'(ys) ||
                vga_colour !== 3'b010) begin
                errors++;
                $display("FAIL clip_px%0d: gnt=%b plot=%b x=%0d y=%0d col=%b, required 100/%b/%0d/%0d/010",
                         p, gnt, vga_plot, vga_x, vga_y, vga_colour, ep, xs, ys);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 3'b100) begin
            errors++;
            $display("FAIL clip_done: done=%b required 100", done);
        end
        req = 3'b000;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clip_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_input_stability();
        set_tile(0, 8'd10, 7'd20, 3'b110);
        req = 3'b001;
        for (int p = 0; p < 9; p++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 3'b001 || vga_x !== 8'(10 + p % 3) || vga_y !== 7'(20 + p / 3) ||
                vga_colour !== 3'b110 || vga_plot !== 1'b1) begin
                errors++;
                $display("FAIL stable_px%0d: gnt=%b x=%0d y=%0d col=%b plot=%b, required 001/%0d/%0d/110/1",
                         p, gnt, vga_x, vga_y, vga_colour, vga_plot, 10 + p % 3, 20 + p / 3);
            end
            if (p == 4) set_tile(0, 8'd50, 7'd30, 3'b001);
        end
        @(negedge clk);
        checks++;
        if (done !== 3'b001) begin
            errors++;
            $display("FAIL stable_done: done=%b required 001", done);
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_clear_priority();
        int clr_err;
        set_tile(1, 8'd30, 7'd40, 3'b101);
        req = 3'b010;
        clear_req = 1'b1;
        clr_err = 0;
        for (int i = 0; i < 19200; i++) begin
            @(negedge clk);
            if (i == 0) clear_req = 1'b0;
            checks++;
            if (vga_plot !== 1'b1 || vga_x !== 8'(i % 160) || vga_y !== 7'(i / 160) ||
                vga_colour !== 3'd0 || gnt !== 3'b000 || busy !== 1'b1) begin
                errors++;
                clr_err++;
                if (clr_err <= 20)
                    $display("FAIL clear_px%0d: plot=%b x=%0d y=%0d col=%0d gnt=%b busy=%b, required 1/%0d/%0d/0/000/1",
                             i, vga_plot, vga_x, vga_y, vga_colour, gnt, busy, i % 160, i / 160);
            end
        end
        @(negedge clk);
        checks++;
        if (clear_done !== 1'b1 || vga_plot !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_done: cdone=%b plot=%b busy=%b, required 1/0/1", clear_done, vga_plot, busy);
        end
        @(negedge clk);
        checks++;
        if (clear_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle: cdone=%b busy=%b, required 0/0", clear_done, busy);
        end
        for (int p = 0; p < 9; p++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 3'b010 || vga_x !== 8'(30 + p % 3) || vga_y !== 7'(40 + p / 3) ||
                vga_colour !== 3'b101 || vga_plot !== 1'b1) begin
                errors++;
                $display("FAIL post_clear_px%0d: gnt=%b x=%0d y=%0d col=%b plot=%b, required 010/%0d/%0d/101/1",
                         p, gnt, vga_x, vga_y, vga_colour, vga_plot, 30 + p % 3, 40 + p / 3);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 3'b010) begin
            errors++;
            $display("FAIL post_clear_done: done=%b required 010", done);
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        set_tile(0, 8'd10, 7'd20, 3'b011);
        set_tile(1, 8'd30, 7'd40, 3'b101);
        req = 3'b010;
        for (int p = 0; p < 5; p++) @(negedge clk);
        checks++;
        if (gnt !== 3'b010 || vga_x !== 8'd31 || vga_y !== 7'd41 || vga_plot !== 1'b1) begin
            errors++;
            $display("FAIL mid_burst_px4: gnt=%b x=%0d y=%0d plot=%b, required 010/31/41/1",
                     gnt, vga_x, vga_y, vga_plot);
        end
        rst = 1'b0;
        req = 3'b011;
        #1;
        checks++;
        if (gnt !== 3'b000 || done !== 3'b000 || busy !== 1'b0 || vga_plot !== 1'b0 ||
            vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0 || clear_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: gnt=%b done=%b busy=%b plot=%b x=%0d y=%0d col=%0d cdone=%b, required all 0",
                     gnt, done, busy, vga_plot, vga_x, vga_y, vga_colour, clear_done);
        end
        @(negedge clk);
        checks++;
        if (done !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done=%b busy=%b required 000/0", done, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b001 || vga_x !== 8'd10 || vga_y !== 7'd20 || vga_colour !== 3'b011) begin
            errors++;
            $display("FAIL reset_first_winner: gnt=%b x=%0d y=%0d col=%b, required 001/10/20/011",
                     gnt, vga_x, vga_y, vga_colour);
        end
        rst = 1'b0;
        req = 3'b000;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_round_robin();
        test_clipping();
        test_input_stability();
        test_clear_priority();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_tile_plot_arbiter.md
# vga_tile_plot_arbiter

Shares the single VGA adapter plot port (x, y, colour, plot) between several drawing requesters: snake movement controller, food placer, score/overlay. Each requester asks for one TILE×TILE block at a base coordinate in one colour. The arbiter grants round-robin and emits the block pixel by pixel. It also runs a full-screen black clear on command from the game-state logic and reports completion.

## Interface

Parameters:

- N_REQ, 3, number of tile requesters
- TILE, 3, tile edge in pixels (TILE*TILE pixels per burst)
- X_MAX, 160, screen width; legal x is 0..X_MAX-1
- Y_MAX, 120, screen height; legal y is 0..Y_MAX-1

Ports:

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-requester tile request level
- req_x  in  8*N_REQ  base x, requester i at bits [8i+7:8i]
- req_y  in  7*N_REQ  base y, requester i at bits [7i+6:7i]
- req_colour  in  3*N_REQ  tile colour, requester i at bits [3i+2:3i]
- clear_req  in  1  request full-screen clear to black
- gnt  out  N_REQ  one-hot; the active burst owner
- done  out  N_REQ  one-cycle pulse to the owner after its last pixel
- clear_done  out  1  one-cycle pulse after the last clear pixel
- busy  out  1  high in any state other than IDLE
- vga_x  out  8  pixel x to adapter
- vga_y  out  7  pixel y to adapter
- vga_colour  out  3  pixel colour to adapter
- vga_plot  out  1  pixel write enable

## Operation

- States: IDLE, DRAW, DONE, CLEAR, CLR_DONE.
- IDLE
  - If clear_req = 1, go to CLEAR with col = 0 and row = 0. Clear beats any req.
  - Otherwise, if any req bit is set, pick the winner round-robin. Search starts at last_winner+1 mod N_REQ.
  - On the same edge, latch the winner's base x, base y and colour.
  - Set the owner index, reset col and row to 0, and go to DRAW.
- DRAW
  - Pixel position: vga_x = base_x + col, vga_y = base_y + row; vga_colour = latched colour.
  - col increments each cycle; at TILE-1 it wraps to 0 and row increments.
  - After the pixel at col = TILE-1, row = TILE-1, go to DONE.
- DONE
  - Drive done[owner] = 1 for this cycle only.
  - Set last_winner = owner and go to IDLE.
- CLEAR
  - vga_colour = 0 and vga_plot = 1 every cycle.
  - x sweeps 0..X_MAX-1 inner, y sweeps 0..Y_MAX-1 outer.
  - After (X_MAX-1, Y_MAX-1), go to CLR_DONE.
- CLR_DONE: clear_done = 1 for one cycle, then go to IDLE.
- gnt[owner] is high through DRAW and DONE and low elsewhere.
- Requesters hold req until done. A requester that is still asserting req in the IDLE cycle after its done is re-arbitrated at lowest priority.
- req, req_x, req_y and req_colour are sampled only in IDLE. Changes during a burst are ignored.
- Clipping
  - Sums are computed 9-bit (x) and 8-bit (y).
  - If base_x+col ≥ X_MAX or base_y+row ≥ Y_MAX, vga_plot = 0 for that cycle. The count still advances and burst length is unchanged.
  - vga_x and vga_y carry the truncated low bits.
- No preemption: clear_req during DRAW waits for IDLE. req during CLEAR waits for IDLE.

## Timing

- Reset state:
  - state = IDLE, last_winner = N_REQ-1 (requester 0 wins first), counters = 0, latched registers = 0.
  - All outputs 0.
- Reset mid-burst: abort immediately to IDLE. No done pulse is emitted.
- All outputs are decoded from registered state, counters and latches. There is no combinational path from req, req_* or clear_req to any output.
- Tile latency, with req seen in IDLE at cycle 0:
  - gnt and first vga_plot at cycle 1.
  - Last pixel at cycle TILE².
  - done at cycle TILE²+1.
  - IDLE at cycle TILE²+2; the next grant starts its first pixel at TILE²+3.
  - Sustained rate: one tile per TILE²+2 cycles (11 with default parameters).
- Clear latency: clear_req seen in IDLE at cycle 0 → X_MAX*Y_MAX plot cycles (19200 with default parameters) from cycle 1 → clear_done at cycle X_MAX*Y_MAX+1.
- busy = 1 from cycle 1 until the cycle after done / clear_done.

## Test plan

- Single tile: req[0] = 1, x = 10, y = 20, colour = 3'b100 → 9 plot cycles covering x 10..12, y 20..22 (x fastest), colour 100, gnt = 001 throughout. done[0] pulses at cycle 10.
- Round-robin: all three req held continuously from reset → grant order 0, 1, 2, 0. Each burst is 11 cycles apart; no requester is granted twice in a row while others are pending.
- Clear priority: clear_req and req[1] asserted together in IDLE → 19200 black plots, then clear_done. Requester 1 is then granted with its original tile.
- Clipping: req[2] with x = 158, y = 118 → 9 cycles; vga_plot is high only for (158,118), (159,118), (158,119), (159,119). done still arrives at cycle 10.
- Input stability: change req_x[7:0] from 10 to 50 mid-burst → all pixels still use base x = 10.
- Reset mid-burst: drop rst at pixel 4 → all outputs 0 at once, no done. After release, requester 0 wins the first arbitration.
